// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detectors: controller state codes,
// overlap mode, and the legacy 11011 pattern constants.
package seq_det_pkg;

  // Controller state codes, kept as plain constants for the legacy detectors.
  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_ARMED    = 2'd2;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } overlap_e;

  // Fixed 11011 pattern used by the original detectors (LSB-aligned, MSB first on the wire).
  localparam logic [7:0]  LEGACY_PATTERN = 8'b0001_1011;
  localparam int unsigned LEGACY_LEN     = 5;

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register plus a saturating count of bits consumed since
// the last clear or restart.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clear,
  input  logic               restart,
  output logic [MAX_LEN-1:0] hist,
  output logic [LEN_W-1:0]   fill
);

  localparam logic [LEN_W-1:0] FillMax = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // Clear wins over a valid bit; restart keeps the shifted bit but zeroes fill.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], in_bit};
      if (restart) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control and a
// saturating match counter. Reset defaults behave as the fixed 11011 detector.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(LEGACY_PATTERN),
  parameter int unsigned        DEF_LEN     = LEGACY_LEN,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int unsigned       LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clear_count,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               primed
);

  localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DefLen   = LEN_W'(DEF_LEN);
  localparam logic [1:0]       StReset  = (DEF_LEN == 0) ? ST_DISABLED : ST_FILLING;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  overlap_e           overlap_q, overlap_d;
  logic [1:0]         state_q, state_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               match;
  logic               restart;

  seq_det_hist #(
    .MAX_LEN (MAX_LEN)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in),
    .clear    (cfg_load),
    .restart  (restart),
    .hist     (hist),
    .fill     (fill)
  );

  // Post-shift view of history and fill, as they will be after this bit.
  always_comb begin
    hist_shift = {hist[MAX_LEN-2:0], in};
    fill_inc   = (fill == MaxLen) ? fill : fill + LEN_W'(1);
  end

  // Compare only the low len bits; a load cycle never matches.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    match   = in_valid && !cfg_load && (len_q != '0) && (fill_inc >= len_q) &&
              (((hist_shift ^ pattern_q) & mask) == '0);
    restart = match && (overlap_q == NON_OVERLAP);
  end

  // Configuration latch with length clamping.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > MaxLen) ? MaxLen : cfg_len;
      overlap_d = overlap_e'(cfg_overlap);
    end
  end

  // Controller: DISABLED / FILLING / ARMED.
  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (cfg_len == '0) ? ST_DISABLED : ST_FILLING;
    end else if (in_valid && (state_q != ST_DISABLED)) begin
      if (restart) begin
        state_d = ST_FILLING;
      end else if (fill_inc >= len_q) begin
        state_d = ST_ARMED;
      end
    end
  end

  // Match pulse and saturating counter; a clear coinciding with a match leaves 1.
  always_comb begin
    y_d   = match;
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // All control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= DefLen;
      overlap_q <= overlap_e'(DEF_OVERLAP);
      state_q   <= StReset;
      y_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      state_q   <= state_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
    end
  end

  assign y           = y_q;
  assign match_count = cnt_q;
  assign primed      = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed streams, a vector table
// for the gapped-input case, and randomized traffic against a queue-based model.
module tb_seq_detector_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int          CNT_MAX = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       clear_count;
  logic       y;
  logic [2:0] match_count;
  logic       primed;

  always #5 clk = ~clk;

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in          (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clear_count (clear_count),
    .y           (y),
    .match_count (match_count),
    .primed      (primed)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bits consumed since last arm/restart, newest at the back.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov;
  bit         m_q[$];
  int         m_cnt;
  bit         m_y;
  bit         m_primed;

  typedef struct {
    bit v;
    bit d;
    bit ey;
    bit ep;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat    = 8'b0001_1011;
    m_len    = 5;
    m_ov     = 1'b1;
    m_q.delete();
    m_cnt    = 0;
    m_y      = 1'b0;
    m_primed = 1'b0;
  endtask

  task automatic model_step();
    bit hit;
    hit = 1'b0;
    if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      m_ov  = cfg_overlap;
      m_q.delete();
    end else if (in_valid) begin
      m_q.push_back(in_bit);
      if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      if (m_len != 0 && m_q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
      end
      if (hit && !m_ov) m_q.delete();
    end
    if (clear_count) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    m_y      = hit;
    m_primed = (m_len != 0) && (m_q.size() >= m_len);
  endtask

  task automatic set_idle();
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_load    = 1'b0;
    clear_count = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("y", 32'(y), 32'(m_y));
    check("match_count", 32'(match_count), 32'(m_cnt));
    check("primed", 32'(primed), 32'(m_primed));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("reset_y", 32'(y), 32'd0);
    check("reset_count", 32'(match_count), 32'd0);
    check("reset_primed", 32'(primed), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic feed_str(input string s, output logic [31:0] ymask);
    ymask = '0;
    for (int i = 0; i < s.len(); i++) begin
      set_idle();
      in_valid = 1'b1;
      in_bit   = (s.getc(i) == "1");
      tick();
      ymask[i] = y;
    end
    set_idle();
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit ov, input bit clr);
    set_idle();
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    clear_count = clr;
    tick();
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ym;
    string       s;
    int          r;

    tbl[0] = '{1, 1, 0, 0};
    tbl[1] = '{0, 1, 0, 0};
    tbl[2] = '{1, 1, 0, 0};
    tbl[3] = '{0, 1, 0, 0};
    tbl[4] = '{1, 0, 0, 0};
    tbl[5] = '{0, 1, 0, 0};
    tbl[6] = '{1, 1, 0, 0};
    tbl[7] = '{0, 1, 0, 0};
    tbl[8] = '{1, 1, 1, 1};
    tbl[9] = '{0, 1, 0, 1};

    set_idle();
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    reset       = 1'b1;
    #3;
    do_reset();

    // Defaults, overlapping 11011011: pulses after bits 5 and 8.
    feed_str("11011011", ym);
    check("ovl_11011011_y", ym, 32'h90);
    check("ovl_11011011_count", 32'(match_count), 32'd2);

    // Non-overlap 11011 on the same stream: single pulse.
    load(8'h1B, 4'd5, 1'b0, 1'b1);
    feed_str("11011011", ym);
    check("novl_11011011_y", ym, 32'h10);
    check("novl_11011011_count", 32'(match_count), 32'd1);

    // Defaults on 1111011, then 1101 overlapping on 1101101.
    do_reset();
    feed_str("1111011", ym);
    check("ovl_1111011_y", ym, 32'h40);
    load(8'h0D, 4'd4, 1'b1, 1'b0);
    feed_str("1101101", ym);
    check("ovl_1101_y", ym, 32'h48);

    // Gapped delivery of 11011.
    do_reset();
    foreach (tbl[i]) begin
      set_idle();
      in_valid = tbl[i].v;
      in_bit   = tbl[i].d;
      tick();
      check($sformatf("gap_y[%0d]", i), 32'(y), 32'(tbl[i].ey));
      check($sformatf("gap_primed[%0d]", i), 32'(primed), 32'(tbl[i].ep));
    end

    // Nine matches saturate a 3-bit counter; clear with a match leaves 1.
    do_reset();
    s = "11011";
    repeat (8) s = {s, "011"};
    feed_str(s, ym);
    check("sat_hits", 32'($countones(ym)), 32'd9);
    check("sat_count", 32'(match_count), 32'd7);
    feed_str("01", ym);
    set_idle();
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    clear_count = 1'b1;
    tick();
    set_idle();
    check("clr_match_y", 32'(y), 32'd1);
    check("clr_match_count", 32'(match_count), 32'd1);

    // Reset mid-stream loses the partial 1101.
    do_reset();
    feed_str("110111101", ym);
    check("pre_reset_count", 32'(match_count), 32'd1);
    do_reset();
    feed_str("1", ym);
    check("post_reset_no_match", ym, 32'd0);

    // Length 0 disables the detector.
    load(8'h00, 4'd0, 1'b1, 1'b0);
    feed_str("0000000000000000", ym);
    check("len0_y", ym, 32'd0);
    check("len0_primed", 32'(primed), 32'd0);

    // A bit arriving with cfg_load is discarded.
    set_idle();
    cfg_load    = 1'b1;
    cfg_pattern = 8'h03;
    cfg_len     = 4'd2;
    cfg_overlap = 1'b1;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    tick();
    set_idle();
    feed_str("1", ym);
    check("load_bit_dropped", ym, 32'd0);
    feed_str("1", ym);
    check("load_then_match", ym, 32'd1);

    // Over-long length is clamped to MAX_LEN.
    load(8'hA5, 4'd15, 1'b0, 1'b0);
    feed_str("10100101", ym);
    check("clamp_y", ym, 32'h80);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      set_idle();
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else begin
        if (r < 8) begin
          cfg_load    = 1'b1;
          cfg_pattern = 8'($urandom);
          cfg_len     = 4'($urandom_range(0, 10));
          cfg_overlap = 1'($urandom_range(0, 1));
        end
        in_valid    = ($urandom_range(0, 3) != 0);
        in_bit      = 1'($urandom_range(0, 1));
        clear_count = ($urandom_range(0, 49) == 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
